temp_bcd_encoder: RTL and testbench
===================================

# temp_bcd_encoder

Converts a signed two's-complement temperature sample into the sign-magnitude BCD format (`temp_value_huns/tens/ones/sign`) consumed by `monitor`, and issues the one-cycle `en` strobe that tells `monitor` a new value is present. It sits between the sensor/sample source and `monitor`, and is the producer end of the BCD temperature interface. Conversion is a sequential shift-add-3 (double-dabble) of one bit per clock, with saturation to ±999.

## Interface
- `WIDTH`, default 11: sample width in bits, two's complement. Legal range 11..16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `sample`  in  WIDTH  signed temperature sample.
- `sample_valid`  in  1  `sample` is presented.
- `sample_ready`  out  1  block is idle and will accept a sample.
- `temp_value_ones`  out  4  BCD ones digit.
- `temp_value_tens`  out  4  BCD tens digit.
- `temp_value_huns`  out  4  BCD hundreds digit.
- `temp_value_sign`  out  1  1 = negative.
- `en`  out  1  one-cycle strobe; the temp_value outputs were updated this cycle.
- `sat`  out  1  the last published value was clamped.

## Operation
- FSM states: IDLE, ABS, SHIFT, DONE.
- IDLE: `sample_ready`=1. On a rising edge with `sample_valid`=1, latch `sample` and go to ABS. Otherwise stay.
- ABS, 1 cycle:
  - neg = sample[WIDTH-1].
  - mag = |sample|, computed at WIDTH+1 bits so that −2^(WIDTH−1) does not overflow.
  - If mag > 999: mag = 999 and sat_next = 1; else sat_next = 0.
  - Load a 10-bit shift register with mag, clear the 12-bit BCD accumulator, set the bit counter to 0. Go to SHIFT.
- SHIFT, exactly 10 cycles:
  - Each cycle, every BCD nibble ≥ 5 has 3 added.
  - Then {bcd, shreg} shifts left by 1.
  - After the 10th shift, go to DONE.
- DONE, 1 cycle: write the huns/tens/ones nibbles, sign = neg AND (mag ≠ 0), and sat = sat_next. Assert `en`=1 for this cycle only. Return to IDLE.
- The temp_value outputs and `sat` are registered and hold their value between DONE cycles.
- Zero is always published with sign 0. The block never emits −000.
- `sample_valid` is ignored outside IDLE, and `sample` is sampled only on the accept edge. Input changes during a conversion have no effect.
- Reset asserted in any state, including mid-SHIFT:
  - FSM goes to IDLE immediately and the conversion is discarded.
  - Outputs return to reset values; no `en` is issued for the aborted sample.
- Reset values: all temp_value digits 0, `temp_value_sign`=0, `en`=0, `sat`=0, `sample_ready`=1.

## Timing
- Edge 0 accepts the sample. ABS occupies edge 1, SHIFT occupies edges 2..11, and DONE is entered at edge 12.
- New outputs and `en`=1 are visible in the cycle after edge 12. `en` drops at edge 13.
- `sample_ready` goes low the cycle after the accept edge. It returns high in the cycle after DONE, so the next accept is possible at edge 13.
- Throughput: one sample per 13 cycles with back-to-back `sample_valid`.
- `en` is never high for two consecutive cycles.
- All outputs are glitch-free registered signals.

## Test plan
- Reset, then `sample`=0 with valid: 12 edges later `en` pulses once; outputs 0/0/0, sign 0, sat 0.
- `sample`=+372: result 3/7/2, sign 0, sat 0. `sample`=−58: result 0/5/8, sign 1.
- `sample`=+999 → 9/9/9, sat 0. `sample`=+1000 → 9/9/9, sat 1. `sample`=−1024 (most negative at WIDTH=11) → 9/9/9, sign 1, sat 1.
- Hold `sample_valid` high with `sample` changing every cycle:
  - one accept every 13 cycles;
  - each published value equals the sample present on its accept edge;
  - `sample_ready` is low for exactly 12 cycles per conversion.
- Publish +123, then assert `rst` low at SHIFT cycle 5 of a −456 conversion:
  - outputs go to 0 asynchronously and no `en` is issued;
  - after release, a new +7 produces 0/0/7.
- Exhaustive sweep of −999..+999 driving a `monitor` instance:
  - published BCD matches the decimal reference;
  - `monitor` consumes exactly one `en` per sample.

Source files
------------

// File: rtl/temp_bcd_encoder.sv
// rtl/temp_bcd_encoder.sv - signed sample to sign-magnitude BCD with saturation and en strobe
module temp_bcd_encoder #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic [3:0]       temp_value_ones,
    output logic [3:0]       temp_value_tens,
    output logic [3:0]       temp_value_huns,
    output logic             temp_value_sign,
    output logic             en,
    output logic             sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ABS   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH:0] MAG_LIMIT = (WIDTH + 1)'(999);
    localparam logic [3:0]     LAST_BIT  = 4'd9;

    state_t           state_q;
    logic [WIDTH-1:0] sample_q;
    logic             neg_q;
    logic             nonzero_q;
    logic             sat_next_q;
    logic [9:0]       shreg_q;
    logic [11:0]      bcd_q;
    logic [3:0]       cnt_q;

    logic             ready_q;
    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    logic [3:0]       huns_q;
    logic             sign_q;
    logic             en_q;
    logic             sat_q;

    logic             sample_neg_d;
    logic [WIDTH:0]   sample_ext_d;
    logic [WIDTH:0]   mag_full_d;
    logic             over_d;
    logic [9:0]       mag_d;
    logic [11:0]      bcd_adj_d;
    logic [21:0]      shifted_d;

    // Magnitude of the latched sample; one extra bit so the most negative code negates cleanly.
    always_comb begin
        sample_neg_d = sample_q[WIDTH-1];
        sample_ext_d = {sample_q[WIDTH-1], sample_q};
        mag_full_d   = sample_neg_d ? (~sample_ext_d + 1'b1) : sample_ext_d;
        over_d       = (mag_full_d > MAG_LIMIT);
        mag_d        = over_d ? 10'd999 : mag_full_d[9:0];
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, shreg} left.
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shifted_d = {bcd_adj_d, shreg_q} << 1;
    end

    // Conversion FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sample_q   <= '0;
            neg_q      <= 1'b0;
            nonzero_q  <= 1'b0;
            sat_next_q <= 1'b0;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            ones_q     <= '0;
            tens_q     <= '0;
            huns_q     <= '0;
            sign_q     <= 1'b0;
            en_q       <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        sample_q <= sample;
                        ready_q  <= 1'b0;
                        state_q  <= S_ABS;
                    end
                end
                S_ABS: begin
                    neg_q      <= sample_neg_d;
                    nonzero_q  <= (mag_d != 10'd0);
                    sat_next_q <= over_d;
                    shreg_q    <= mag_d;
                    bcd_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd_q   <= shifted_d[21:10];
                    shreg_q <= shifted_d[9:0];
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    huns_q  <= bcd_q[11:8];
                    tens_q  <= bcd_q[7:4];
                    ones_q  <= bcd_q[3:0];
                    sign_q  <= neg_q & nonzero_q;
                    sat_q   <= sat_next_q;
                    en_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sample_ready    = ready_q;
    assign temp_value_ones = ones_q;
    assign temp_value_tens = tens_q;
    assign temp_value_huns = huns_q;
    assign temp_value_sign = sign_q;
    assign en              = en_q;
    assign sat             = sat_q;

endmodule

// File: tb/tb_temp_bcd_encoder.sv
// tb/tb_temp_bcd_encoder.sv - directed self-checking bench for temp_bcd_encoder
module tb_temp_bcd_encoder;

    logic        clk;
    logic        rst;
    logic [10:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  temp_value_ones;
    logic [3:0]  temp_value_tens;
    logic [3:0]  temp_value_huns;
    logic        temp_value_sign;
    logic        en;
    logic        sat;

    int checks = 0;
    int errors = 0;

    temp_bcd_encoder #(.WIDTH(11)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .temp_value_ones (temp_value_ones),
        .temp_value_tens (temp_value_tens),
        .temp_value_huns (temp_value_huns),
        .temp_value_sign (temp_value_sign),
        .en              (en),
        .sat             (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ref_pack(input int v);
        int   m;
        logic s;
        logic st;
        m  = (v < 0) ? -v : v;
        st = (m > 999);
        if (st) m = 999;
        s  = (v < 0) && (m != 0);
        ref_pack = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10), s, st};
    endfunction

    function automatic logic [14:0] obs_pack();
        obs_pack = {temp_value_huns, temp_value_tens, temp_value_ones, temp_value_sign, sat};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for ready, presents v for one accept edge, then checks latency, value and en width.
    task automatic convert(input int v, input logic [14:0] exp, input string tag);
        int waited;
        int lat;
        waited = 0;
        while (sample_ready !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        sample       = 11'(v);
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        sample       = 11'h2aa;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (en === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 12);
        check({tag, "_value"}, obs_pack(), exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_en_drop"}, en, 1'b0);
    endtask

    logic [14:0] expq[$];
    int          ready_run;
    int          since_accept;
    int          accepts;
    int          en_seen;
    logic        prev_en;
    int          v;

    initial begin
        rst          = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_value", obs_pack(), 15'd0);
        check("reset_en", en, 1'b0);
        check("reset_ready", sample_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        convert(0,     {4'd0, 4'd0, 4'd0, 1'b0, 1'b0}, "zero");
        convert(372,   {4'd3, 4'd7, 4'd2, 1'b0, 1'b0}, "p372");
        convert(-58,   {4'd0, 4'd5, 4'd8, 1'b1, 1'b0}, "m58");
        convert(999,   {4'd9, 4'd9, 4'd9, 1'b0, 1'b0}, "p999");
        convert(1000,  {4'd9, 4'd9, 4'd9, 1'b0, 1'b1}, "p1000");
        convert(-1024, {4'd9, 4'd9, 4'd9, 1'b1, 1'b1}, "m1024");
        convert(1023,  {4'd9, 4'd9, 4'd9, 1'b0, 1'b1}, "p1023");
        convert(-1,    {4'd0, 4'd0, 4'd1, 1'b1, 1'b0}, "m1");

        // Back-to-back: valid held high, sample changes every cycle.
        ready_run    = 0;
        since_accept = -1;
        accepts      = 0;
        en_seen      = 0;
        prev_en      = 1'b0;
        sample_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (en === 1'b1) begin
                en_seen++;
                if (expq.size() > 0) check("b2b_value", obs_pack(), expq.pop_front());
                else check("b2b_unexpected_en", 1'b1, 1'b0);
            end
            if (prev_en === 1'b1) check("b2b_en_single", en, 1'b0);
            prev_en = en;
            if (sample_ready === 1'b0) begin
                ready_run++;
            end else if (ready_run > 0) begin
                check("b2b_ready_low", ready_run, 12);
                ready_run = 0;
            end
            v = int'($urandom_range(1998)) - 999;
            sample = 11'(v);
            if (sample_ready === 1'b1) begin
                if (since_accept >= 0) check("b2b_interval", since_accept, 13);
                expq.push_back(ref_pack(v));
                accepts++;
                since_accept = 0;
            end
            if (since_accept >= 0) since_accept++;
            @(posedge clk);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (en === 1'b1) begin
                en_seen++;
                if (expq.size() > 0) check("b2b_drain_value", obs_pack(), expq.pop_front());
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_en_count", en_seen, accepts);
        check("b2b_accepts", accepts, 6);

        // Reset in the middle of a conversion.
        convert(123, {4'd1, 4'd2, 4'd3, 1'b0, 1'b0}, "p123");
        sample       = 11'(-456);
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hold_during_conv", obs_pack(), {4'd1, 4'd2, 4'd3, 1'b0, 1'b0});
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_value", obs_pack(), 15'd0);
        check("async_rst_ready", sample_ready, 1'b1);
        check("async_rst_en", en, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        en_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (en === 1'b1) en_seen++;
        end
        check("abort_no_en", en_seen, 0);
        check("abort_value_kept_zero", obs_pack(), 15'd0);
        convert(7, {4'd0, 4'd0, 4'd7, 1'b0, 1'b0}, "p7");

        // Sweep of the unsaturated range against a decimal reference.
        for (int s = -999; s <= 999; s++) begin
            convert(s, ref_pack(s), "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
